tlm_antilog_pipe: RTL and testbench
===================================

Name: tlm_antilog_pipe

Overview:
- Downstream consumer of the truncated binary-logarithm converter in the approximate log multiplier datapath.
- Accepts two truncated logarithms {k,y}, adds them, and converts the sum back to the linear domain (antilog shift) to form the approximate product.
- Two-stage pipeline with valid/ready handshake on both sides; full throughput of one product per cycle when not stalled.

Parameters:
- M, 11, truncation parameter; fraction width FW = 16-M (5), log width LW = 4+FW (9).
- PW, 32, product width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts the operand pair this cycle.
- tlog_a  in  LW  truncated log of operand A, {k[3:0], y[FW-1:0]}.
- tlog_b  in  LW  truncated log of operand B.
- zero_a  in  1  operand A is zero. The converter maps 0 and 1 to the same log, so this flag disambiguates.
- zero_b  in  1  operand B is zero.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts the product.
- product  out  PW  approximate product.

Behaviour:
- Reset: rst is synchronous and active-high. On reset, s1_valid, s2_valid and out_valid are 0, product is 0, and in_ready is 1 from the first cycle after reset.
- Handshake: a transfer occurs when valid and ready are both 1 at a clock edge.
  - product must hold stable while out_valid=1 and out_ready=0.
  - in_ready may depend combinationally on out_ready. No other input-to-output combinational path exists.
- Stage advance:
  - adv2 = !s2_valid | out_ready.
  - adv1 = !s1_valid | adv2.
  - in_ready = adv1.
- Stage 1 (on in_valid & in_ready):
  - s1_sum = tlog_a + tlog_b, zero-extended to LW+1 bits (10). No overflow: the maximum is 0x3FE.
  - s1_zero = zero_a | zero_b.
  - s1_valid = 1.
  - If stage 1 advances with no new input, s1_valid becomes 0.
- Stage 2 (on adv2 & s1_valid):
  - Split the sum: K = s1_sum[LW:FW] (0..31), F = s1_sum[FW-1:0].
  - Mantissa mant = {1'b1, F} (FW+1 bits).
  - product = (mant << K) >> FW, computed in PW+FW+1 bits and truncated to PW.
  - For K < FW the low fraction bits are discarded (truncation).
  - If s1_zero, product = 0.
  - s2_valid = 1. If stage 2 advances with s1_valid=0, s2_valid becomes 0.
- Latency and throughput: 2 cycles from input transfer to out_valid, with no bubbles under continuous out_ready=1.
- Backpressure:
  - With out_ready held at 0, at most two items are buffered and in_ready drops after two accepts.
  - Releasing out_ready resumes in-order delivery with no loss or duplication.
- Simultaneous events: on the same edge, stage 2 may drain to the output while stage 1 loads stage 2 and a new input loads stage 1.
- Reset mid-operation: all in-flight items are discarded and no out_valid is asserted in the cycle after reset.
- Maximum input: K=31, F=30 gives product 0xF8000000, which fits in PW=32 bits.

Optional Feature:
- Macro: TLM_ANTILOG_ROUND_EN.
- Defined: mant = {1'b1, F, 1'b1} and product = (mant << K) >> (FW+1). Appending the half-LSB midpoint reduces the negative truncation bias. Zero handling and latency are unchanged.
- Undefined: plain truncated antilog as specified in Behaviour.

Decomposition:
- Shared package tlm_pkg holds:
  - constants FW, LW, KW=4, PW;
  - a typedef for the log word {k,y};
  - a function splitting the sum into K and F.
- Sub-module tlm_antilog_shift: purely combinational mant/K/F-to-product shifter. The rounding variant of the macro lives here, and it is instantiated in stage 2.

Test Plan:
- Each scenario below applies with the macro undefined / defined.
- 3x5: tlog_a=9'h030, tlog_b=9'h048 -> sum 0x078 (K=3, F=24) -> product 14 in both builds, out_valid two cycles after accept.
- 255x255: tlog_a=tlog_b=9'h0FF -> K=15, F=30 -> product 63488 (undefined) / 64000 (defined).
- Extremes:
  - 1x1 (both tlogs 0) -> product 1.
  - tlog_a=tlog_b=9'h1FF -> 0xF8000000 (undefined) / 0xFA000000 (defined).
  - zero_a=1 with any tlogs -> product 0.
- Backpressure: stream 4 items with out_ready=0 -> in_ready falls after the 2nd accept and product stays stable. Raising out_ready delivers all 4 in order with no duplicates.
- Throughput: 16 back-to-back inputs with out_ready=1 -> 16 outputs on consecutive cycles starting at cycle 2.
- Reset: assert rst with 2 items in flight -> no out_valid afterwards, product=0, in_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/tlm_pkg.sv
// tlm_pkg: shared widths, log-word types and sum splitter for the log-multiplier antilog path
package tlm_pkg;
  localparam int M = 11;
  localparam int FW = 16 - M;
  localparam int KW = 4;
  localparam int LW = KW + FW;
  localparam int PW = 32;
  typedef struct packed {
    logic [KW-1:0] k;
    logic [FW-1:0] y;
  } tlog_t;
  typedef struct packed {
    logic [KW:0]   k;
    logic [FW-1:0] f;
  } split_t;
  function automatic split_t split_sum(input logic [LW:0] sum);
    return split_t'(sum);
  endfunction
endpackage

// File: rtl/tlm_antilog_shift.sv
// tlm_antilog_shift: combinational antilog shifter; TLM_ANTILOG_ROUND_EN appends a half-LSB before truncating
module tlm_antilog_shift
  import tlm_pkg::*;
(
  input  logic [KW:0]   k,
  input  logic [FW-1:0] f,
  output logic [PW-1:0] product
);
  localparam int WW = PW + FW + 2;
`ifdef TLM_ANTILOG_ROUND_EN
  assign product = PW'((WW'({1'b1, f, 1'b1}) << k) >> (FW + 1));
`else
  assign product = PW'((WW'({1'b1, f}) << k) >> FW);
`endif
endmodule

// File: rtl/tlm_antilog_pipe.sv
// tlm_antilog_pipe: two-stage log-add and antilog pipeline with valid/ready; TLM_ANTILOG_ROUND_EN selects rounding
module tlm_antilog_pipe
  import tlm_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [LW-1:0] tlog_a,
  input  logic [LW-1:0] tlog_b,
  input  logic          zero_a,
  input  logic          zero_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] product
);
  logic          s1_valid, s1_zero, s2_valid, adv1, adv2;
  logic [LW:0]   s1_sum;
  logic [PW-1:0] shifted;
  split_t        sp;
  assign adv2 = !s2_valid || out_ready;
  assign adv1 = !s1_valid || adv2;
  assign in_ready = adv1;
  assign out_valid = s2_valid;
  assign sp = split_sum(s1_sum);
  tlm_antilog_shift u_shift (
    .k       (sp.k),
    .f       (sp.f),
    .product (shifted)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_zero  <= 1'b0;
      s1_sum   <= '0;
      s2_valid <= 1'b0;
      product  <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sum  <= {1'b0, tlog_a} + {1'b0, tlog_b};
          s1_zero <= zero_a || zero_b;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) product <= s1_zero ? '0 : shifted;
      end
    end
  end
endmodule

// File: tb/tb_tlm_antilog_pipe.sv
// tb_tlm_antilog_pipe: directed checks of the antilog pipeline, both rounding builds
module tb_tlm_antilog_pipe;
  import tlm_pkg::*;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [LW-1:0] tlog_a = '0;
  logic [LW-1:0] tlog_b = '0;
  logic          zero_a = 1'b0;
  logic          zero_b = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] product;
  int            tests = 0;
  int            fails = 0;
  logic [LW-1:0] sa [16];
  logic [LW-1:0] sb [16];
  logic [PW-1:0] se [16];
`ifdef TLM_ANTILOG_ROUND_EN
  localparam logic [31:0] E255 = 32'd64000;
  localparam logic [31:0] EMAX = 32'hFA000000;
`else
  localparam logic [31:0] E255 = 32'd63488;
  localparam logic [31:0] EMAX = 32'hF8000000;
`endif
  tlm_antilog_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tlog_a    (tlog_a),
    .tlog_b    (tlog_b),
    .zero_a    (zero_a),
    .zero_b    (zero_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_prod(input logic [LW:0] s);
    longint m;
    m = 64'(32 + int'(s[FW-1:0]));
`ifdef TLM_ANTILOG_ROUND_EN
    return 32'(((2 * m + 1) << s[LW:FW]) >> 6);
`else
    return 32'((m << s[LW:FW]) >> 5);
`endif
  endfunction
  task automatic single(input string tag, input logic [LW-1:0] a, input logic [LW-1:0] b,
                        input logic za, input logic zb, input logic [31:0] exp);
    @(posedge clk); #1;
    in_valid = 1'b1; tlog_a = a; tlog_b = b; zero_a = za; zero_b = zb; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; zero_a = 1'b0; zero_b = 1'b0;
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk(tag, product, exp);
  endtask
  task automatic stream(input string tag, input int n, input int hold, input bit bp);
    int  idx, oidx;
    bit  acc, del;
    idx = 0; oidx = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; tlog_a = sa[0]; tlog_b = sb[0]; out_ready = (hold == 0);
    for (int c = 0; c < 60 && oidx < n; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (bp && c >= 2 && c < hold) begin
        chk({tag, "_inrdy_low"}, 32'(in_ready), 32'd0);
        chk({tag, "_hold"}, product, se[0]);
      end
      if (del) begin
        chk({tag, "_data"}, product, se[oidx]);
        if (!bp) chk({tag, "_cycle"}, c, oidx + 2);
        oidx++;
      end
      @(posedge clk); #1;
      if (acc) idx++;
      in_valid = idx < n;
      if (idx < n) begin tlog_a = sa[idx]; tlog_b = sb[idx]; end
      out_ready = (c + 1 >= hold);
    end
    chk({tag, "_count"}, oidx, n);
    @(negedge clk);
    chk({tag, "_nodup"}, 32'(out_valid), 32'd0);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_product", product, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_idle", 32'(out_valid), 32'd0);
    single("p3x5", 9'h030, 9'h048, 1'b0, 1'b0, 32'd14);
    single("p255", 9'h0FF, 9'h0FF, 1'b0, 1'b0, E255);
    single("p1x1", 9'h000, 9'h000, 1'b0, 1'b0, 32'd1);
    single("pmax", 9'h1FF, 9'h1FF, 1'b0, 1'b0, EMAX);
    single("zero_a", 9'h1FF, 9'h1FF, 1'b1, 1'b0, 32'd0);
    single("zero_b", 9'h030, 9'h048, 1'b0, 1'b1, 32'd0);
    sa[0] = 9'h030; sb[0] = 9'h048; se[0] = 32'd14;
    sa[1] = 9'h000; sb[1] = 9'h000; se[1] = 32'd1;
    sa[2] = 9'h0FF; sb[2] = 9'h0FF; se[2] = E255;
    sa[3] = 9'h1FF; sb[3] = 9'h1FF; se[3] = EMAX;
    stream("bp", 4, 4, 1'b1);
    for (int i = 0; i < 16; i++) begin
      sa[i] = LW'(i << FW);
      sb[i] = LW'(i);
      se[i] = ref_prod({1'b0, sa[i]} + {1'b0, sb[i]});
    end
    stream("tput", 16, 0, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; tlog_a = 9'h030; tlog_b = 9'h048;
    @(posedge clk); #1;
    tlog_a = 9'h0FF; tlog_b = 9'h0FF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_inflight", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_product", product, 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_flushed", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_flushed2", 32'(out_valid), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
